de4_sopc_version_reader: RTL and testbench
==========================================

# de4_sopc_version_reader

Avalon-MM read master that fetches the build-version words from the on-chip version ROM into a local shadow buffer after reset or on request, and computes an XOR checksum over them. It sits on the SOPC fabric as a master facing the version ROM slave. Captured words go to local status logic, such as a debug UART dumper or LED/status registers, without fabric access after the fetch.

## Interface
Parameters:
- NUM_WORDS, 5, number of 32-bit words fetched (addresses 0..NUM_WORDS-1)
- ADDR_W, 3, Avalon word-address width; NUM_WORDS <= 2**ADDR_W
- READ_LATENCY, 1, fixed slave read latency in cycles (>= 1)
- AUTO_START, 1, 1 = begin a fetch automatically on the first cycle after reset deasserts

Ports:
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle pulse; requests a (re)fetch
- avm_address  out  ADDR_W  word address of the current read
- avm_read  out  1  read request
- avm_byteenable  out  4  constant 4'b1111
- avm_waitrequest  in  1  slave stall; the request is held while high
- avm_readdata  in  32  read data, valid READ_LATENCY cycles after acceptance
- word_sel  in  ADDR_W  shadow-buffer read select
- word_out  out  32  shadow word[word_sel]; 0 if word_sel >= NUM_WORDS
- checksum  out  32  XOR of all words captured in the current fetch
- busy  out  1  fetch in progress
- ver_valid  out  1  all NUM_WORDS words captured since the last start/reset

## Operation
- FSM states: IDLE, REQ, WAIT_DATA, DONE.
- IDLE:
  - busy=0.
  - On start (or the first post-reset cycle when AUTO_START=1): clear addr counter, checksum, and ver_valid; go to REQ.
- REQ:
  - avm_read=1, avm_address=addr.
  - While avm_waitrequest=1, hold address and read stable.
  - On the edge where avm_read & !avm_waitrequest, the request is accepted: load the latency counter with READ_LATENCY-1 and go to WAIT_DATA.
- WAIT_DATA:
  - avm_read=0.
  - Count down. On the edge where the count is 0:
    - buffer[addr] <= avm_readdata
    - checksum <= checksum ^ avm_readdata
  - Then, if addr == NUM_WORDS-1, go to DONE; else addr <= addr+1 and go to REQ.
- DONE:
  - ver_valid=1, busy=0.
  - On start, perform the same clear as IDLE and go to REQ. Buffer words are overwritten in place as they are re-read.
- Only one read is ever outstanding. No writes are issued.
- start while busy (REQ/WAIT_DATA) is ignored.
- word_out is a combinational read of the buffer and is usable at any time. Words not yet captured in the current fetch hold their previous contents (0 after reset).
- Reset mid-fetch:
  - Immediately: avm_read=0 and state=IDLE.
  - Counters, buffer, and checksum are cleared.
  - A read the slave already accepted is discarded; its data is not captured.

## Timing
- Reset values:
  - avm_read=0, avm_address=0, busy=0, ver_valid=0, checksum=0, word_out=0.
  - avm_byteenable=4'hF always.
- With AUTO_START=1, avm_read rises in the second cycle after reset deasserts (one IDLE cycle).
- With waitrequest=0, each word costs 1+READ_LATENCY cycles. A full fetch takes NUM_WORDS*(1+READ_LATENCY) cycles from the first REQ to DONE: 10 cycles at the defaults.
- Each waitrequest cycle adds exactly one cycle.
- busy is high from the cycle after start is sampled through the final capture edge. ver_valid rises in the same cycle busy falls.
- checksum is updated at each capture edge, so its final value is stable when ver_valid=1.

## Test plan
- Default params, ROM model with words 0x20120301, 0x0000BEEF, 0x12345678, 0xA5A5A5A5, 0x00000005, waitrequest=0, AUTO_START → five reads on addresses 0..4:
  - buffer matches the ROM contents
  - checksum = XOR of the five words
  - ver_valid rises 11 cycles after reset deasserts
- waitrequest held high 3 cycles on address 2 → avm_address stays 2 and avm_read stays 1 throughout; the fetch completes 3 cycles later; contents are correct.
- READ_LATENCY=3 → the data on avm_readdata exactly 3 cycles after each acceptance is captured; junk driven at latency 1 and 2 is ignored; total fetch is 20 cycles.
- start pulses while busy → no restart; a start pulse in DONE with the ROM contents changed → ver_valid drops, a new fetch runs, and the buffer and checksum reflect the new contents.
- reset asserted during WAIT_DATA of address 3 → outputs go to reset values asynchronously; after release the fetch restarts at address 0 and completes correctly.
- word_sel=7 → word_out=0; word_sel=4 before the fetch → 0; word_sel=4 after the fetch → 0x00000005.

Source files
------------

// File: rtl/de4_sopc_version_reader_if.sv
// Avalon-MM read channel between the version reader (master) and the version ROM (slave).
interface de4_sopc_version_reader_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;

  modport master (
    output avm_address, avm_read, avm_byteenable,
    input  avm_waitrequest, avm_readdata
  );

  modport slave (
    input  avm_address, avm_read, avm_byteenable,
    output avm_waitrequest, avm_readdata
  );
endinterface

// File: rtl/de4_sopc_version_reader.sv
// Fetches NUM_WORDS build-version words from the version ROM into a shadow buffer
// and keeps a running XOR checksum of the words captured in the current fetch.
module de4_sopc_version_reader #(
  parameter int NUM_WORDS    = 5,
  parameter int ADDR_W       = 3,
  parameter int READ_LATENCY = 1,
  parameter int AUTO_START   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  de4_sopc_version_reader_if.master  avm,
  input  logic [ADDR_W-1:0]          word_sel,
  output logic [31:0]                word_out,
  output logic [31:0]                checksum,
  output logic                       busy,
  output logic                       ver_valid
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LAT_W-1:0]  lat_reg;
  logic [31:0]       checksum_reg;
  logic              auto_reg;
  logic              capture;
  logic              last_word;
  logic [31:0]       words [NUM_WORDS];

  assign capture   = (state_reg == S_WAIT) && (lat_reg == '0);
  assign last_word = (addr_reg == ADDR_W'(NUM_WORDS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      lat_reg      <= '0;
      checksum_reg <= '0;
      auto_reg     <= (AUTO_START != 0);
    end else begin
      case (state_reg)
        S_IDLE: begin
          // auto_reg only ever fires on the first cycle after reset
          auto_reg <= 1'b0;
          if (start || auto_reg) begin
            addr_reg     <= '0;
            checksum_reg <= '0;
            state_reg    <= S_REQ;
          end
        end
        S_REQ: begin
          if (!avm.avm_waitrequest) begin
            lat_reg   <= LAT_W'(READ_LATENCY - 1);
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (capture) begin
            checksum_reg <= checksum_reg ^ avm.avm_readdata;
            if (last_word) begin
              state_reg <= S_DONE;
            end else begin
              addr_reg  <= addr_reg + ADDR_W'(1);
              state_reg <= S_REQ;
            end
          end else begin
            lat_reg <= lat_reg - LAT_W'(1);
          end
        end
        S_DONE: begin
          if (start) begin
            addr_reg     <= '0;
            checksum_reg <= '0;
            state_reg    <= S_REQ;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // One register per shadow word so word_out can be read combinationally at any time
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : gen_word
      logic [31:0] word_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          word_reg <= '0;
        end else if (capture && (addr_reg == ADDR_W'(gi))) begin
          word_reg <= avm.avm_readdata;
        end
      end
      assign words[gi] = word_reg;
    end
  endgenerate

  always_comb begin
    word_out = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (word_sel == ADDR_W'(i)) begin
        word_out = words[i];
      end
    end
  end

  assign avm.avm_read       = (state_reg == S_REQ);
  assign avm.avm_address    = addr_reg;
  assign avm.avm_byteenable = 4'hF;
  assign checksum           = checksum_reg;
  assign busy               = (state_reg == S_REQ) || (state_reg == S_WAIT);
  assign ver_valid          = (state_reg == S_DONE);
endmodule

// File: tb/tb_de4_sopc_version_reader.sv
// Scoreboard bench: two readers (read latency 1 and 3) on ROM models; stimulus queues
// expected addresses/checksums/fetch times, per-DUT monitors pop and compare.
module tb_de4_sopc_version_reader;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start1 = 1'b0;
  logic          start3 = 1'b0;
  logic [AW-1:0] word_sel = '0;
  logic [31:0]   word_out1, word_out3, checksum1, checksum3;
  logic          busy1, busy3, vv1, vv3;

  de4_sopc_version_reader_if #(.ADDR_W(AW)) bus1 ();
  de4_sopc_version_reader_if #(.ADDR_W(AW)) bus3 ();

  always #5 clk = ~clk;

  de4_sopc_version_reader #(.NUM_WORDS(5), .ADDR_W(AW), .READ_LATENCY(1), .AUTO_START(1)) u_dut1 (
    .clk(clk), .reset(rst), .start(start1), .avm(bus1), .word_sel(word_sel),
    .word_out(word_out1), .checksum(checksum1), .busy(busy1), .ver_valid(vv1)
  );

  de4_sopc_version_reader #(.NUM_WORDS(5), .ADDR_W(AW), .READ_LATENCY(3), .AUTO_START(1)) u_dut3 (
    .clk(clk), .reset(rst), .start(start3), .avm(bus3), .word_sel(word_sel),
    .word_out(word_out3), .checksum(checksum3), .busy(busy3), .ver_valid(vv3)
  );

  // Hand-computed ROM images and their XOR checksums
  logic [31:0] rom_a [5] = '{32'h20120301, 32'h0000BEEF, 32'h12345678, 32'hA5A5A5A5, 32'h00000005};
  logic [31:0] rom_b [5] = '{32'h20130415, 32'hCAFEF00D, 32'h0BADC0DE, 32'h5A5A5A5A, 32'h00000006};
  localparam logic [31:0] SUM_A = 32'h97834E36;
  localparam logic [31:0] SUM_B = 32'hBB1A6E9A;

  logic [31:0] rom [8];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ROM slave models: data valid exactly READ_LATENCY cycles after acceptance, junk otherwise
  int            cnt1 = 0, cnt3 = 0, wait_left = 0;
  logic [AW-1:0] wait_addr = AW'(2);
  logic [31:0]   d1, d3;

  always @(posedge clk) begin
    automatic logic          acc   = bus1.avm_read && !bus1.avm_waitrequest;
    automatic logic          stall = bus1.avm_read && bus1.avm_waitrequest;
    automatic logic [AW-1:0] a     = bus1.avm_address;
    #1;
    if (rst) begin
      cnt1 = 0;
    end else begin
      if (cnt1 > 0) cnt1--;
      if (acc) begin cnt1 = 1; d1 = rom[a]; end
      if (stall && wait_left > 0) wait_left--;
    end
    bus1.avm_readdata    = (cnt1 == 1) ? d1 : (32'hDEAD0000 | cyc[15:0]);
    bus1.avm_waitrequest = bus1.avm_read && (bus1.avm_address == wait_addr) && (wait_left > 0);
  end

  always @(posedge clk) begin
    automatic logic          acc = bus3.avm_read && !bus3.avm_waitrequest;
    automatic logic [AW-1:0] a   = bus3.avm_address;
    #1;
    if (rst) begin
      cnt3 = 0;
    end else begin
      if (cnt3 > 0) cnt3--;
      if (acc) begin cnt3 = 3; d3 = rom[a]; end
    end
    bus3.avm_readdata    = (cnt3 == 1) ? d3 : (32'hBAD00000 | cyc[15:0]);
    bus3.avm_waitrequest = 1'b0;
  end

  // Scoreboard queues
  logic [AW-1:0] addr_q1[$], addr_q3[$];
  logic [31:0]   sum_q1[$], sum_q3[$];
  int            cyc_q1[$], cyc_q3[$];
  int            t0_1 = 0, t0_3 = 0;
  logic          prev1 = 1'b0, prev3 = 1'b0;

  task automatic expect_fetch1(input logic [31:0] sum, input int cycles);
    for (int i = 0; i < 5; i++) addr_q1.push_back(AW'(i));
    sum_q1.push_back(sum);
    cyc_q1.push_back(cycles);
  endtask

  task automatic expect_fetch3(input logic [31:0] sum, input int cycles);
    for (int i = 0; i < 5; i++) addr_q3.push_back(AW'(i));
    sum_q3.push_back(sum);
    cyc_q3.push_back(cycles);
  endtask

  task automatic flush_queues();
    addr_q1.delete(); sum_q1.delete(); cyc_q1.delete();
    addr_q3.delete(); sum_q3.delete(); cyc_q3.delete();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev1 = 1'b0;
    end else begin
      if (bus1.avm_read && !bus1.avm_waitrequest) begin
        if (addr_q1.size() == 0) begin
          n_tests++; n_fail++;
          $display("[TB] FAIL dut1_unexpected_read: address %0d, expected no read", bus1.avm_address);
        end else begin
          chk("dut1_read_addr", 32'(bus1.avm_address), 32'(addr_q1.pop_front()));
        end
      end else if (bus1.avm_read && bus1.avm_waitrequest && addr_q1.size() > 0) begin
        chk("dut1_stall_addr", 32'(bus1.avm_address), 32'(addr_q1[0]));
      end
      if (vv1 && !prev1) begin
        if (sum_q1.size() == 0) begin
          n_tests++; n_fail++;
          $display("[TB] FAIL dut1_unexpected_done: checksum 0x%08h, expected no completion", checksum1);
        end else begin
          $display("[TB] dut1 fetch done: checksum=0x%08h cycles=%0d", checksum1, cyc - t0_1);
          chk("dut1_checksum", checksum1, sum_q1.pop_front());
          chk("dut1_fetch_cycles", 32'(cyc - t0_1), 32'(cyc_q1.pop_front()));
        end
      end
      prev1 = vv1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev3 = 1'b0;
    end else begin
      if (bus3.avm_read && !bus3.avm_waitrequest) begin
        if (addr_q3.size() == 0) begin
          n_tests++; n_fail++;
          $display("[TB] FAIL dut3_unexpected_read: address %0d, expected no read", bus3.avm_address);
        end else begin
          chk("dut3_read_addr", 32'(bus3.avm_address), 32'(addr_q3.pop_front()));
        end
      end
      if (vv3 && !prev3) begin
        if (sum_q3.size() == 0) begin
          n_tests++; n_fail++;
          $display("[TB] FAIL dut3_unexpected_done: checksum 0x%08h, expected no completion", checksum3);
        end else begin
          $display("[TB] dut3 fetch done: checksum=0x%08h cycles=%0d", checksum3, cyc - t0_3);
          chk("dut3_checksum", checksum3, sum_q3.pop_front());
          chk("dut3_fetch_cycles", 32'(cyc - t0_3), 32'(cyc_q3.pop_front()));
        end
      end
      prev3 = vv3;
    end
  end

  task automatic wait_done(input int which, input int budget);
    for (int i = 0; i < budget && !(which == 1 ? vv1 : vv3); i++) @(negedge clk);
    #1;
    chk($sformatf("dut%0d_done_within_budget", which), 32'(which == 1 ? vv1 : vv3), 32'd1);
  endtask

  task automatic check_words(input int which, input logic [31:0] exp [5]);
    for (int i = 0; i < 5; i++) begin
      word_sel = AW'(i);
      #1;
      chk($sformatf("dut%0d_word[%0d]", which, i), (which == 1) ? word_out1 : word_out3, exp[i]);
    end
    word_sel = AW'(7);
    #1;
    chk($sformatf("dut%0d_word_sel7", which), (which == 1) ? word_out1 : word_out3, 32'h0);
  endtask

  task automatic check_reset();
    word_sel = '0;
    #1;
    chk("rst_avm_read", 32'(bus1.avm_read), 32'd0);
    chk("rst_avm_address", 32'(bus1.avm_address), 32'd0);
    chk("rst_byteenable", 32'(bus1.avm_byteenable), 32'hF);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_ver_valid", 32'(vv1), 32'd0);
    chk("rst_checksum", checksum1, 32'h0);
    chk("rst_word_out", word_out1, 32'h0);
    chk("rst_dut3_ver_valid", 32'(vv3), 32'd0);
    chk("rst_dut3_checksum", checksum3, 32'h0);
  endtask

  task automatic pulse_start1();
    @(negedge clk);
    start1 = 1'b1;
    t0_1   = cyc;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  initial begin
    bus1.avm_waitrequest = 1'b0; bus1.avm_readdata = '0;
    bus3.avm_waitrequest = 1'b0; bus3.avm_readdata = '0;
    for (int i = 0; i < 8; i++) rom[i] = (i < 5) ? rom_a[i] : 32'h0;

    // Reset state, and word 4 reads 0 before any fetch
    repeat (3) @(negedge clk);
    check_reset();
    word_sel = AW'(4);
    #1;
    chk("word_sel4_before_fetch", word_out1, 32'h0);

    // Auto-start fetch on both readers
    expect_fetch1(SUM_A, 11);
    expect_fetch3(SUM_A, 21);
    @(negedge clk);
    rst = 1'b0; t0_1 = cyc; t0_3 = cyc;
    #1;
    chk("idle_cycle_read_low", 32'(bus1.avm_read), 32'd0);
    @(negedge clk);
    chk("second_cycle_read_high", 32'(bus1.avm_read), 32'd1);
    chk("second_cycle_busy", 32'(busy1), 32'd1);
    wait_done(1, 40);
    wait_done(3, 40);
    check_words(1, rom_a);
    check_words(3, rom_a);

    // Waitrequest held 3 cycles on address 2; extra starts while busy are ignored
    wait_left = 3;
    expect_fetch1(SUM_A, 14);
    pulse_start1();
    chk("start_drops_ver_valid", 32'(vv1), 32'd0);
    chk("start_sets_busy", 32'(busy1), 32'd1);
    repeat (2) @(negedge clk);
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    repeat (3) @(negedge clk);
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    wait_done(1, 60);
    check_words(1, rom_a);

    // Refetch from DONE with new ROM contents
    for (int i = 0; i < 5; i++) rom[i] = rom_b[i];
    expect_fetch1(SUM_B, 11);
    pulse_start1();
    chk("refetch_ver_valid_low", 32'(vv1), 32'd0);
    wait_done(1, 40);
    check_words(1, rom_b);

    // Reset during WAIT_DATA of address 3
    expect_fetch1(SUM_B, 11);
    pulse_start1();
    begin
      int i;
      for (i = 0; i < 40; i++) begin
        if (bus1.avm_read && !bus1.avm_waitrequest && bus1.avm_address == AW'(3)) break;
        @(negedge clk);
      end
      chk("reached_addr3_accept", 32'(i < 40), 32'd1);
    end
    @(negedge clk);
    chk("in_wait_data_busy", 32'(busy1), 32'd1);
    #2;
    rst = 1'b1;
    check_reset();
    flush_queues();
    @(negedge clk);
    expect_fetch1(SUM_B, 11);
    expect_fetch3(SUM_B, 21);
    @(negedge clk);
    rst = 1'b0; t0_1 = cyc; t0_3 = cyc;
    wait_done(1, 40);
    wait_done(3, 40);
    check_words(1, rom_b);
    check_words(3, rom_b);
    chk("scoreboard_drained", 32'(addr_q1.size() + sum_q1.size() + addr_q3.size() + sum_q3.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
